// File: rtl/cordic_pkg.sv
// Shared definitions for the cordic_arb scheduler: FSM encoding, operand width
// and the engine reset-hold length used after power-up.
package cordic_pkg;

   localparam int W         = 16;
   localparam int INIT_HOLD = 2;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_IDLE,
      ST_LOAD,
      ST_RUN,
      ST_DONE
   } state_t;

endpackage

// File: rtl/cordic_arb_rr_pick.sv
// Rotating-priority encoder: first requesting channel at or after ptr,
// wrapping from NCH-1 back to 0.
module rr_pick #(
   parameter int NCH = 4,
   parameter int PW  = 2
) (
   input  logic [NCH-1:0] req,
   input  logic [PW-1:0]  ptr,
   output logic [PW-1:0]  grant,
   output logic           any
);

   logic found;

   always_comb begin
      grant = '0;
      found = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (!found && req[(int'(ptr) + i) % NCH]) begin
            grant = PW'((int'(ptr) + i) % NCH);
            found = 1'b1;
         end
      end
   end

   assign any = |req;

endmodule

// File: rtl/cordic_arb.sv
// Round-robin scheduler sharing one serial cordic16 engine among NCH requesters.
// Define CORDIC_ARB_TMO_EN to add the load-to-rdy watchdog (err output).
//
// state | meaning
// INIT  | engine held in reset (e_rst) for INIT_HOLD clocks after rst release
// IDLE  | waiting for a request; grant picked and operands latched on exit
// LOAD  | e_load and ack[g] strobe
// RUN   | engine converting, waiting for e_rdy (or watchdog)
// DONE  | done[g] strobe, pointer advances past g
module cordic_arb
   import cordic_pkg::*;
#(
   parameter int NCH = 4,
   parameter int TMO = 63
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   req,
   input  logic [W*NCH-1:0] xi,
   input  logic [W*NCH-1:0] yi,
   input  logic [W*NCH-1:0] zi,
   input  logic [NCH-1:0]   mi,
   output logic [NCH-1:0]   ack,
   output logic [W-1:0]     e_xi,
   output logic [W-1:0]     e_yi,
   output logic [W-1:0]     e_zi,
   output logic             e_mi,
   output logic             e_load,
   output logic             e_rst,
   input  logic [W-1:0]     e_xo,
   input  logic [W-1:0]     e_yo,
   input  logic [W-1:0]     e_zo,
   input  logic             e_rdy,
   output logic [W-1:0]     xo,
   output logic [W-1:0]     yo,
   output logic [W-1:0]     zo,
   output logic             mo,
   output logic [NCH-1:0]   done,
   output logic             err,
   output logic             busy
);

   localparam int PW = $clog2(NCH);

   if (NCH < 2 || NCH > 8 || TMO < 1 || TMO > 63) begin : g_param_chk
      $error("cordic_arb: NCH must be 2..8 and TMO 1..63");
   end

   state_t          state, state_nxt;
   logic [PW-1:0]   ptr, g_r, grant;
   logic            any;
   logic [1:0]      init_cnt;

   rr_pick #(.NCH(NCH), .PW(PW)) u_pick (
      .req   (req),
      .ptr   (ptr),
      .grant (grant),
      .any   (any)
   );

`ifdef CORDIC_ARB_TMO_EN
   logic [5:0] tcnt;
   logic       tmo_hit;
   logic       err_q;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_INIT;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      e_load    = 1'b0;
      ack       = '0;
      done      = '0;
      busy      = 1'b0;
`ifdef CORDIC_ARB_TMO_EN
      tmo_hit   = 1'b0;
`endif
      case (state)
         ST_INIT: if (init_cnt == 2'(INIT_HOLD - 1)) state_nxt = ST_IDLE;
         ST_IDLE: if (any) state_nxt = ST_LOAD;
         ST_LOAD: begin
            e_load     = 1'b1;
            ack[g_r]   = 1'b1;
            busy       = 1'b1;
            state_nxt  = ST_RUN;
         end
         ST_RUN: begin
            busy = 1'b1;
            // a same-cycle e_rdy beats the watchdog
            if (e_rdy) state_nxt = ST_DONE;
`ifdef CORDIC_ARB_TMO_EN
            else if (tcnt == 6'(TMO - 1)) begin
               tmo_hit   = 1'b1;
               state_nxt = ST_DONE;
            end
`endif
         end
         ST_DONE: begin
            busy      = 1'b1;
            done[g_r] = 1'b1;
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         init_cnt <= '0;
         e_rst    <= 1'b1;
         ptr      <= '0;
         g_r      <= '0;
         e_xi     <= '0;
         e_yi     <= '0;
         e_zi     <= '0;
         e_mi     <= 1'b0;
         xo       <= '0;
         yo       <= '0;
         zo       <= '0;
         mo       <= 1'b0;
      end else begin
         case (state)
            ST_INIT: begin
               init_cnt <= init_cnt + 2'd1;
               if (init_cnt == 2'(INIT_HOLD - 1)) e_rst <= 1'b0;
            end
            ST_IDLE: if (any) begin
               g_r  <= grant;
               e_xi <= xi[grant*W +: W];
               e_yi <= yi[grant*W +: W];
               e_zi <= zi[grant*W +: W];
               e_mi <= mi[grant];
            end
            ST_RUN: begin
               if (e_rdy) begin
                  xo <= e_xo;
                  yo <= e_yo;
                  zo <= e_zo;
                  mo <= e_mi;
               end
`ifdef CORDIC_ARB_TMO_EN
               else if (tmo_hit) begin
                  xo    <= '0;
                  yo    <= '0;
                  zo    <= '0;
                  mo    <= e_mi;
                  e_rst <= 1'b1;
               end
`endif
            end
            ST_DONE: begin
               ptr <= (g_r == PW'(NCH - 1)) ? '0 : g_r + 1'b1;
`ifdef CORDIC_ARB_TMO_EN
               e_rst <= 1'b0;
`endif
            end
            default: ;
         endcase
      end
   end

`ifdef CORDIC_ARB_TMO_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tcnt  <= '0;
         err_q <= 1'b0;
      end else begin
         if (state == ST_LOAD)     tcnt <= '0;
         else if (state == ST_RUN) tcnt <= tcnt + 6'd1;
         if (state == ST_RUN)      err_q <= tmo_hit;
      end
   end
   assign err = (state == ST_DONE) && err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_arb.sv
// Scoreboard bench for cordic_arb: a behavioural engine model, a round-robin
// reference model feeding an expected-result queue, and a done-strobe monitor.
module tb_cordic_arb;

   localparam int NCH = 4;
   localparam int W   = 16;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [NCH-1:0]   req = '0;
   logic [W*NCH-1:0] xi = '0, yi = '0, zi = '0;
   logic [NCH-1:0]   mi = '0;
   logic [NCH-1:0]   ack, done;
   logic [W-1:0]     e_xi, e_yi, e_zi, xo, yo, zo;
   logic             e_mi, e_load, e_rst, mo, err, busy;
   logic [W-1:0]     e_xo = '0, e_yo = '0, e_zo = '0;
   logic             e_rdy = 1'b0;

   cordic_arb #(.NCH(NCH), .TMO(63)) dut (
      .clk(clk), .rst(rst), .req(req), .xi(xi), .yi(yi), .zi(zi), .mi(mi),
      .ack(ack), .e_xi(e_xi), .e_yi(e_yi), .e_zi(e_zi), .e_mi(e_mi),
      .e_load(e_load), .e_rst(e_rst), .e_xo(e_xo), .e_yo(e_yo), .e_zo(e_zo),
      .e_rdy(e_rdy), .xo(xo), .yo(yo), .zo(zo), .mo(mo), .done(done),
      .err(err), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         ch;
      logic [W-1:0] x, y, z;
      logic       m;
      logic       e;
   } exp_t;

   exp_t q[$];
   int total = 0;
   int bad   = 0;

   // requester model state
   logic [W-1:0] opx[NCH], opy[NCH], opz[NCH];
   logic         opm[NCH];
   int           ptr_m     = 0;
   bit           hold_mode = 1'b0;
   int           hold_n    = 0;
   int           hold_acks = 0;

   // engine model: -1 random latency, -2 never answers, >=0 fixed latency
   int           eng_force = -1;
   int           eng_cnt   = -1;
   logic [3*W-1:0] eng_res;

   function automatic logic [3*W-1:0] eng_fn(logic [W-1:0] x, logic [W-1:0] y,
                                             logic [W-1:0] z, logic m);
      logic [W-1:0] rx, ry, rz;
      rx = ~x + y;
      ry = y ^ z;
      rz = z + {15'b0, m} + 16'h0100;
      return {rx, ry, rz};
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, expv);
      end
   endtask

   // engine: samples and drives on the falling edge
   initial begin
      forever begin
         @(negedge clk);
         e_rdy = 1'b0;
         e_xo  = W'($urandom);
         e_yo  = W'($urandom);
         e_zo  = W'($urandom);
         if (!rst || e_rst) eng_cnt = -1;
         else if (e_load) begin
            eng_res = eng_fn(e_xi, e_yi, e_zi, e_mi);
            if (eng_force >= 0)       eng_cnt = eng_force;
            else if (eng_force == -2) eng_cnt = 1000000;
            else                      eng_cnt = $urandom_range(0, 6);
         end else if (eng_cnt == 0) begin
            e_rdy = 1'b1;
            {e_xo, e_yo, e_zo} = eng_res;
            eng_cnt = -1;
         end else if (eng_cnt > 0) eng_cnt--;
         else if ($urandom_range(0, 5) == 0) e_rdy = 1'b1;
      end
   end

   // monitor: ack/load pairing, requester drop, done scoreboard
   initial begin
      exp_t ex;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (ack != '0) begin
               total++;
               if (!e_load || !$onehot(ack)) begin
                  bad++;
                  $display("FAIL ack_load: ack=%b e_load=%b want onehot ack with e_load=1", ack, e_load);
               end
               hold_acks++;
               if (!hold_mode)              req = req & ~ack;
               else if (hold_acks >= hold_n) req = '0;
            end else if (e_load) begin
               total++;
               bad++;
               $display("FAIL load_no_ack: e_load=1 ack=%b want one ack bit", ack);
            end
            if (done != '0) begin
               total++;
               if (q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_done: done=%b want none", done);
               end else begin
                  ex = q.pop_front();
                  if (done !== NCH'(1 << ex.ch) || xo !== ex.x || yo !== ex.y ||
                      zo !== ex.z || mo !== ex.m || err !== ex.e) begin
                     bad++;
                     $display("FAIL result ch%0d: got done=%b x=%h y=%h z=%h m=%b err=%b want done=%b x=%h y=%h z=%h m=%b err=%b",
                              ex.ch, done, xo, yo, zo, mo, err,
                              NCH'(1 << ex.ch), ex.x, ex.y, ex.z, ex.m, ex.e);
                  end
               end
            end
         end
      end
   end

   task automatic pack_ops();
      for (int c = 0; c < NCH; c++) begin
         xi[c*W +: W] = opx[c];
         yi[c*W +: W] = opy[c];
         zi[c*W +: W] = opz[c];
         mi[c]        = opm[c];
      end
   endtask

   task automatic wait_drain(input string nm);
      int n = 0;
      while ((q.size() != 0 || busy || req != '0) && n < 3000) begin
         @(negedge clk);
         n++;
      end
      total++;
      if (n >= 3000) begin
         bad++;
         $display("FAIL drain_%s: %0d results still pending after %0d clocks, want 0", nm, q.size(), n);
      end
   endtask

   // reference model: serve pending set in rotating order from the model pointer
   task automatic push_expected(input logic [NCH-1:0] set, input bit hold, input int n,
                                input bit tmo);
      logic [NCH-1:0] pend;
      int p, g;
      exp_t ex;
      logic [3*W-1:0] r;
      pend = set;
      p = ptr_m;
      for (int k = 0; k < n; k++) begin
         g = -1;
         for (int i = 0; i < NCH; i++)
            if (g < 0 && pend[(p + i) % NCH]) g = (p + i) % NCH;
         r     = eng_fn(opx[g], opy[g], opz[g], opm[g]);
         ex.ch = g;
         ex.m  = opm[g];
         ex.e  = tmo;
         if (tmo) {ex.x, ex.y, ex.z} = '0;
         else     {ex.x, ex.y, ex.z} = r;
         q.push_back(ex);
         if (!hold) pend[g] = 1'b0;
         p = (g + 1) % NCH;
      end
      ptr_m = p;
   endtask

   task automatic batch(input logic [NCH-1:0] set, input bit hold, input int n,
                        input bit tmo, input string nm);
      for (int c = 0; c < NCH; c++) begin
         opx[c] = W'($urandom);
         opy[c] = W'($urandom);
         opz[c] = W'($urandom);
         opm[c] = 1'($urandom);
      end
      pack_ops();
      push_expected(set, hold, (hold ? n : $countones(set)), tmo);
      hold_mode = hold;
      hold_n    = n;
      hold_acks = 0;
      req       = set;
      wait_drain(nm);
   endtask

   initial begin
      logic [NCH-1:0] rs;
      int n;
      // reset state
      repeat (2) @(negedge clk);
      chk("rst_e_rst", 64'(e_rst), 64'd1);
      chk("rst_outs", 64'({ack, done, busy, e_load, err}), 64'd0);
      chk("rst_xo", 64'({xo, yo, zo}), 64'd0);
      rst = 1'b1;
      @(negedge clk);
      chk("init_hold1", 64'(e_rst), 64'd1);
      @(negedge clk);
      chk("init_hold2", 64'(e_rst), 64'd0);

      // single request on ch0 with fixed operands
      for (int c = 0; c < NCH; c++) begin
         opx[c] = 16'h1111 * 16'(c + 1); opy[c] = '0; opz[c] = 16'h0055; opm[c] = 1'b0;
      end
      opx[0] = 16'h4000;
      pack_ops();
      push_expected(4'b0001, 1'b0, 1, 1'b0);
      hold_mode = 1'b0;
      req = 4'b0001;
      @(negedge clk);
      chk("single_ack_c1", 64'({ack, e_load}), 64'({4'b0001, 1'b1}));
      chk("single_e_xi", 64'({e_xi, e_yi, e_mi}), 64'({16'h4000, 16'h0000, 1'b0}));
      wait_drain("single");

      // ptr now 1: 1,2,3 then wrap so ch0 precedes ch3
      batch(4'b1110, 1'b0, 0, 1'b0, "trio");
      batch(4'b1001, 1'b0, 0, 1'b0, "wrap");
      batch(4'b1111, 1'b1, 5, 1'b0, "fair");

      for (int t = 0; t < 20; t++) begin
         rs = NCH'($urandom_range(1, (1 << NCH) - 1));
         n  = $urandom_range(1, 6);
         batch(rs, 1'($urandom_range(0, 1)), n, 1'b0, "rand");
      end

      // reset during RUN: result lost, pointer back to 0
      eng_force = 20;
      pack_ops();
      hold_mode = 1'b0;
      req = 4'b0100;
      n = 0;
      while (ack == '0 && n < 20) begin @(negedge clk); n++; end
      chk("midrst_ack_seen", 64'(n < 20), 64'd1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_outs", 64'({e_rst, busy, done, ack}), 64'({1'b1, 1'b0, 4'b0, 4'b0}));
      rst = 1'b1;
      ptr_m = 0;
      eng_force = -1;
      repeat (30) @(negedge clk);
      chk("midrst_idle", 64'({e_rst, busy}), 64'd0);
      batch(4'b0110, 1'b0, 0, 1'b0, "after_rst");

`ifdef CORDIC_ARB_TMO_EN
      eng_force = -2;
      batch(4'b0010, 1'b0, 0, 1'b1, "tmo");
      eng_force = 62;
      batch(4'b1000, 1'b0, 0, 1'b0, "tmo_edge");
      eng_force = -1;
      batch(4'b0101, 1'b0, 0, 1'b0, "tmo_after");
`endif

      repeat (5) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
